// File: rtl/silife_grid_core.sv
// Parametrised Game-of-Life grid engine, rule B3/S23.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   en                    - free-run: one generation per cycle while idle
//   wr_en, row_select,
//   grid_in, grid_out     - row write port and combinational row read port
//   run_start, run_len    - start an autonomous burst of run_len generations
//   busy, done            - burst in progress / one-cycle end-of-burst pulse
//   gen_count             - generations computed since reset (wraps)
//   stable, empty         - last step changed nothing / no live cells
module silife_grid_core #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HEIGHT   = 32,
  parameter int unsigned ROW_BITS = 5,
  parameter bit          TOROIDAL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] row_select,
  input  logic [WIDTH-1:0]    grid_in,
  output logic [WIDTH-1:0]    grid_out,
  input  logic                run_start,
  input  logic [7:0]          run_len,
  output logic                busy,
  output logic                done,
  output logic [15:0]         gen_count,
  output logic                stable,
  output logic                empty
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                          state_q;
  logic [7:0]                      remaining_q;
  logic [HEIGHT-1:0][WIDTH-1:0]    grid_q;
  logic [HEIGHT-1:0][WIDTH-1:0]    next_grid;
  logic [15:0]                     gen_count_q;
  logic                            busy_q, done_q, stable_q;
  logic                            in_range, step, write;

  // Grid framed by a one-cell halo: row p / column q of pad is grid row p-1 / column q-1.
  // The halo holds wrapped cells in toroidal mode and zeros otherwise.
  logic [HEIGHT+1:0][WIDTH+1:0]    pad;

  for (genvar p = 0; p < HEIGHT + 2; p++) begin : g_pad
    localparam int unsigned Src  = (p == 0) ? HEIGHT - 1 : (p == HEIGHT + 1) ? 0 : p - 1;
    localparam bit          Live = ((p > 0) && (p < HEIGHT + 1)) || TOROIDAL;
    logic [WIDTH-1:0] row;
    assign row    = Live ? grid_q[Src] : '0;
    assign pad[p] = {TOROIDAL ? row[0] : 1'b0, row, TOROIDAL ? row[WIDTH-1] : 1'b0};
  end

  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [3:0] cnt;
      assign cnt = 4'(pad[r][c])     + 4'(pad[r][c+1])   + 4'(pad[r][c+2]) +
                   4'(pad[r+1][c])                       + 4'(pad[r+1][c+2]) +
                   4'(pad[r+2][c])   + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
      assign next_grid[r][c] = (cnt == 4'd3) || (grid_q[r][c] && (cnt == 4'd2));
    end
  end

  always_comb begin
    in_range = 32'(row_select) < HEIGHT;
    grid_out = in_range ? grid_q[row_select] : '0;
    empty    = ~|grid_q;
    // In RUN every cycle steps; in IDLE a write or a burst start outranks free-run.
    step     = (state_q == StRun) || (!wr_en && !run_start && en);
    write    = (state_q == StIdle) && wr_en && in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      grid_q      <= '0;
      gen_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (step) begin
        grid_q      <= next_grid;
        gen_count_q <= gen_count_q + 16'd1;
        stable_q    <= (next_grid == grid_q);
      end else if (write) begin
        grid_q[row_select] <= grid_in;
        stable_q           <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!wr_en && run_start) begin
            if (run_len == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              remaining_q <= run_len;
              state_q     <= StRun;
              busy_q      <= 1'b1;
            end
          end
        end
        StRun: begin
          remaining_q <= remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_count_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_silife_grid_core.sv
module tb_silife_grid_core;

  logic       clk = 1'b0, reset = 1'b0, en = 1'b0, wr_en = 1'b0, run_start = 1'b0;
  logic [4:0] row_select = '0;
  logic [7:0] grid_in = '0, run_len = '0;

  logic [7:0]  grid_out, grid_out_t, grid_out_h;
  logic        busy, done, stable, empty;
  logic        busy_t, done_t, stable_t, empty_t;
  logic        busy_h, done_h, stable_h, empty_h;
  logic [15:0] gen_count, gen_count_t, gen_count_h;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  silife_grid_core #(.WIDTH(8), .HEIGHT(32), .ROW_BITS(5), .TOROIDAL(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .row_select(row_select),
    .grid_in(grid_in), .grid_out(grid_out), .run_start(run_start), .run_len(run_len),
    .busy(busy), .done(done), .gen_count(gen_count), .stable(stable), .empty(empty)
  );

  silife_grid_core #(.WIDTH(8), .HEIGHT(32), .ROW_BITS(5), .TOROIDAL(1'b1)) dut_t (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .row_select(row_select),
    .grid_in(grid_in), .grid_out(grid_out_t), .run_start(run_start), .run_len(run_len),
    .busy(busy_t), .done(done_t), .gen_count(gen_count_t), .stable(stable_t),
    .empty(empty_t)
  );

  silife_grid_core #(.WIDTH(8), .HEIGHT(24), .ROW_BITS(5), .TOROIDAL(1'b0)) dut_h (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .row_select(row_select),
    .grid_in(grid_in), .grid_out(grid_out_h), .run_start(run_start), .run_len(run_len),
    .busy(busy_h), .done(done_h), .gen_count(gen_count_h), .stable(stable_h),
    .empty(empty_h)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [7:0] v);
    wr_en = 1'b1; row_select = 5'(r); grid_in = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    reset = 1'b1;
    #2;
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL reset_gen: got %0h want %0h", gen_count, e[15:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL reset_busy: got %b want %b", busy, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL reset_done: got %b want %b", done, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (empty !== e[0]) begin
      n_bad++; $display("FAIL reset_empty: got %b want %b", empty, e[0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (stable !== e[0]) begin
      n_bad++; $display("FAIL reset_stable: got %b want %b", stable, e[0]);
    end
    reset = 1'b0;
  endtask

  task automatic test_blinker();
    pulse_reset();
    write_row(1, 8'h07);
    exp_q.push_back(32'h02); exp_q.push_back(32'h02); exp_q.push_back(32'h02);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    en = 1'b1; tick(); en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      row_select = 5'(r); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (grid_out !== e[7:0]) begin
        n_bad++; $display("FAIL blink1_row%0d: got %h want %h", r, grid_out, e[7:0]);
      end
    end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL blink1_gen: got %0d want %0d", gen_count, e[15:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (stable !== e[0]) begin
      n_bad++; $display("FAIL blink1_stable: got %b want %b", stable, e[0]);
    end
    exp_q.push_back(32'h00); exp_q.push_back(32'h07); exp_q.push_back(32'h00);
    exp_q.push_back(32'd2);
    en = 1'b1; tick(); en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      row_select = 5'(r); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (grid_out !== e[7:0]) begin
        n_bad++; $display("FAIL blink2_row%0d: got %h want %h", r, grid_out, e[7:0]);
      end
    end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL blink2_gen: got %0d want %0d", gen_count, e[15:0]);
    end
  endtask

  // Burst on a still-life block; a write and en attempted during RUN must be ignored.
  task automatic test_block_run();
    int count, guard;
    pulse_reset();
    write_row(4, 8'h18);
    write_row(5, 8'h18);
    exp_q.push_back(32'd5); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'h18); exp_q.push_back(32'h18); exp_q.push_back(32'h00);
    exp_q.push_back(32'd1); exp_q.push_back(32'd5);
    run_len = 8'd5; run_start = 1'b1; tick(); run_start = 1'b0;
    count = 0; guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      if (count == 0) begin
        wr_en = 1'b1; row_select = 5'd0; grid_in = 8'hff; en = 1'b1;
      end else begin
        wr_en = 1'b0; en = 1'b0;
      end
      count++; guard++;
      tick();
    end
    wr_en = 1'b0; en = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (count !== int'(e)) begin
      n_bad++; $display("FAIL block_busy_cycles: got %0d want %0d", count, e);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL block_done: got %b want %b", done, e[0]); end
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin
      n_bad++; $display("FAIL block_done_pulse: got %b want %b", done, e[0]);
    end
    row_select = 5'd4; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL block_row4: got %h want %h", grid_out, e[7:0]);
    end
    row_select = 5'd5; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL block_row5: got %h want %h", grid_out, e[7:0]);
    end
    row_select = 5'd0; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL run_write_ignored: got %h want %h", grid_out, e[7:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (stable !== e[0]) begin
      n_bad++; $display("FAIL block_stable: got %b want %b", stable, e[0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL block_gen: got %0d want %0d", gen_count, e[15:0]);
    end
  endtask

  // run_start in the done cycle is accepted.
  task automatic test_back_to_back();
    pulse_reset();
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd3);
    run_len = 8'd2; run_start = 1'b1; tick(); run_start = 1'b0;
    tick(); tick();
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL b2b_done1: got %b want %b", done, e[0]); end
    run_len = 8'd1; run_start = 1'b1; tick(); run_start = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL b2b_busy: got %b want %b", busy, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL b2b_gen1: got %0d want %0d", gen_count, e[15:0]);
    end
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL b2b_idle: got %b want %b", busy, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL b2b_done2: got %b want %b", done, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL b2b_gen2: got %0d want %0d", gen_count, e[15:0]);
    end
  endtask

  task automatic test_torus();
    pulse_reset();
    write_row(0, 8'h81);
    write_row(31, 8'h81);
    exp_q.push_back(32'd1); exp_q.push_back(32'h81); exp_q.push_back(32'h81);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    en = 1'b1; tick(); en = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (empty !== e[0]) begin
      n_bad++; $display("FAIL flat_corner_empty: got %b want %b", empty, e[0]);
    end
    row_select = 5'd0; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out_t !== e[7:0]) begin
      n_bad++; $display("FAIL torus_row0: got %h want %h", grid_out_t, e[7:0]);
    end
    row_select = 5'd31; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out_t !== e[7:0]) begin
      n_bad++; $display("FAIL torus_row31: got %h want %h", grid_out_t, e[7:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (stable_t !== e[0]) begin
      n_bad++; $display("FAIL torus_stable: got %b want %b", stable_t, e[0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (empty_t !== e[0]) begin
      n_bad++; $display("FAIL torus_empty: got %b want %b", empty_t, e[0]);
    end
  endtask

  task automatic test_write_priority();
    pulse_reset();
    exp_q.push_back(32'h55); exp_q.push_back(32'd0);
    exp_q.push_back(32'h00); exp_q.push_back(32'hAA);
    wr_en = 1'b1; en = 1'b1; row_select = 5'd3; grid_in = 8'h55;
    tick();
    wr_en = 1'b0; en = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL wr_prio_row: got %h want %h", grid_out, e[7:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL wr_prio_gen: got %0d want %0d", gen_count, e[15:0]);
    end
    write_row(31, 8'hAA);
    row_select = 5'd31; #1;
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out_h !== e[7:0]) begin
      n_bad++; $display("FAIL oob_row: got %h want %h", grid_out_h, e[7:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL row31_write: got %h want %h", grid_out, e[7:0]);
    end
  endtask

  task automatic test_run_len_zero();
    pulse_reset();
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    run_len = 8'd0; run_start = 1'b1; tick(); run_start = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL rl0_busy: got %b want %b", busy, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL rl0_done: got %b want %b", done, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL rl0_gen: got %0d want %0d", gen_count, e[15:0]);
    end
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL rl0_pulse: got %b want %b", done, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL rl0_busy2: got %b want %b", busy, e[0]); end
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    write_row(1, 8'h07);
    exp_q.push_back(32'd2); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'h00);
    run_len = 8'd10; run_start = 1'b1; tick(); run_start = 1'b0;
    tick(); tick();
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL mid_gen_before: got %0d want %0d", gen_count, e[15:0]);
    end
    reset = 1'b1; row_select = 5'd1;
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (busy !== e[0]) begin n_bad++; $display("FAIL mid_busy: got %b want %b", busy, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (done !== e[0]) begin n_bad++; $display("FAIL mid_done: got %b want %b", done, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL mid_gen: got %0d want %0d", gen_count, e[15:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (empty !== e[0]) begin n_bad++; $display("FAIL mid_empty: got %b want %b", empty, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (grid_out !== e[7:0]) begin
      n_bad++; $display("FAIL mid_row1: got %h want %h", grid_out, e[7:0]);
    end
    reset = 1'b0;
  endtask

  task automatic test_gen_wrap();
    pulse_reset();
    exp_q.push_back(32'hFFFF); exp_q.push_back(32'h0000);
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    en = 1'b1;
    repeat (65535) tick();
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL wrap_pre: got %h want %h", gen_count, e[15:0]);
    end
    tick();
    en = 1'b0;
    e = exp_q.pop_front(); n_cmp++;
    if (gen_count !== e[15:0]) begin
      n_bad++; $display("FAIL wrap_gen: got %h want %h", gen_count, e[15:0]);
    end
    e = exp_q.pop_front(); n_cmp++;
    if (empty !== e[0]) begin n_bad++; $display("FAIL wrap_empty: got %b want %b", empty, e[0]); end
    e = exp_q.pop_front(); n_cmp++;
    if (stable !== e[0]) begin
      n_bad++; $display("FAIL wrap_stable: got %b want %b", stable, e[0]);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_blinker();
    test_block_run();
    test_back_to_back();
    test_torus();
    test_write_priority();
    test_run_len_zero();
    test_reset_mid_burst();
    test_gen_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
